// File: rtl/superh16_rat_ckpt.sv
// superh16_rat_ckpt: rename-stage register alias table with intra-group
// RAW/WAW bypass, NUM_CKPT in-order branch checkpoints and a retirement RAT
// for exception-flush recovery.
// Optional macro SUPERH16_RAT_ZERO_REG_EN hardwires arch reg 0 to phys 0.

// Per-slot lookup: source tags and old destination tag, bypassed from older slots.
module superh16_rat_ckpt_slot #(
  parameter int NUM_ARCH  = 32,
  parameter int ARCH_BITS = 5,
  parameter int PHYS_BITS = 8,
  parameter int WIDTH     = 12,
  parameter int SRCS      = 3,
  parameter int SLOT      = 0,
  parameter bit ZERO_EN   = 1'b0
) (
  input  logic [NUM_ARCH-1:0][PHYS_BITS-1:0] spec_rat,
  input  logic [SRCS-1:0][ARCH_BITS-1:0]     src_arch,
  input  logic [ARCH_BITS-1:0]               own_dst_arch,
  input  logic [WIDTH-1:0]                   dst_valid,
  input  logic [WIDTH-1:0][ARCH_BITS-1:0]    dst_arch,
  input  logic [WIDTH-1:0][PHYS_BITS-1:0]    dst_phys,
  output logic [SRCS-1:0][PHYS_BITS-1:0]     src_phys,
  output logic [PHYS_BITS-1:0]               old_phys
);
  // Scan older slots in order so the youngest prior writer overrides the RAT.
  always_comb begin
    for (int s = 0; s < SRCS; s++) begin
      src_phys[s] = spec_rat[src_arch[s]];
      for (int j = 0; j < SLOT; j++)
        if (dst_valid[j] && dst_arch[j] == src_arch[s]) src_phys[s] = dst_phys[j];
      if (ZERO_EN && src_arch[s] == '0) src_phys[s] = '0;
    end
    old_phys = spec_rat[own_dst_arch];
    for (int j = 0; j < SLOT; j++)
      if (dst_valid[j] && dst_arch[j] == own_dst_arch) old_phys = dst_phys[j];
    if (ZERO_EN && own_dst_arch == '0) old_phys = '0;
  end
endmodule

module superh16_rat_ckpt #(
  parameter int NUM_ARCH  = 32,
  parameter int PHYS_BITS = 8,
  parameter int WIDTH     = 12,
  parameter int SRCS      = 3,
  parameter int NUM_CKPT  = 8,
  localparam int ARCH_BITS = $clog2(NUM_ARCH),
  localparam int CK_BITS   = $clog2(NUM_CKPT),
  localparam int SLOT_BITS = $clog2(WIDTH)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    ren_fire,
  input  logic [WIDTH*SRCS-1:0][ARCH_BITS-1:0]    ren_src_arch,
  output logic [WIDTH*SRCS-1:0][PHYS_BITS-1:0]    ren_src_phys,
  input  logic [WIDTH-1:0]                        ren_dst_valid,
  input  logic [WIDTH-1:0][ARCH_BITS-1:0]         ren_dst_arch,
  input  logic [WIDTH-1:0][PHYS_BITS-1:0]         ren_dst_phys,
  output logic [WIDTH-1:0][PHYS_BITS-1:0]         ren_old_phys,
  input  logic                                    ckpt_req,
  input  logic [SLOT_BITS-1:0]                    ckpt_slot,
  output logic [CK_BITS-1:0]                      ckpt_id,
  output logic                                    ckpt_full,
  input  logic                                    br_resolve_valid,
  input  logic [CK_BITS-1:0]                      br_resolve_id,
  input  logic                                    br_mispredict,
  input  logic [CK_BITS-1:0]                      br_mispredict_id,
  input  logic [WIDTH-1:0]                        cmt_valid,
  input  logic [WIDTH-1:0][ARCH_BITS-1:0]         cmt_arch,
  input  logic [WIDTH-1:0][PHYS_BITS-1:0]         cmt_phys,
  input  logic                                    flush
);
`ifdef SUPERH16_RAT_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  typedef logic [NUM_ARCH-1:0][PHYS_BITS-1:0] rat_t;

  rat_t                spec_rat, rrat, rrat_nxt;
  rat_t                ckpt [NUM_CKPT];
  rat_t [WIDTH-1:0]    grp_upd;   // spec RAT after slots 0..i of this group
  logic [NUM_CKPT-1:0] ckpt_vld, vld_nxt, clr_mask;
  logic [CK_BITS-1:0]  tail, span, off;
  logic                alloc;

  assign ckpt_id   = tail;
  assign ckpt_full = ckpt_vld[tail];
  assign alloc     = ren_fire && ckpt_req && !ckpt_vld[tail] && !flush && !br_mispredict;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slot
    superh16_rat_ckpt_slot #(
      .NUM_ARCH(NUM_ARCH), .ARCH_BITS(ARCH_BITS), .PHYS_BITS(PHYS_BITS),
      .WIDTH(WIDTH), .SRCS(SRCS), .SLOT(i), .ZERO_EN(ZERO_EN)
    ) u_slot (
      .spec_rat     (spec_rat),
      .src_arch     (ren_src_arch[i*SRCS +: SRCS]),
      .own_dst_arch (ren_dst_arch[i]),
      .dst_valid    (ren_dst_valid),
      .dst_arch     (ren_dst_arch),
      .dst_phys     (ren_dst_phys),
      .src_phys     (ren_src_phys[i*SRCS +: SRCS]),
      .old_phys     (ren_old_phys[i])
    );
  end

  // Prefix of group writes: entry i feeds partial checkpoints, last entry the spec RAT.
  always_comb begin
    rat_t acc;
    acc = spec_rat;
    for (int i = 0; i < WIDTH; i++) begin
      if (ren_dst_valid[i] && !(ZERO_EN && ren_dst_arch[i] == '0))
        acc[ren_dst_arch[i]] = ren_dst_phys[i];
      grp_upd[i] = acc;
    end
  end

  // Retirement RAT next state: this cycle's commits, highest slot wins.
  always_comb begin
    rrat_nxt = rrat;
    for (int i = 0; i < WIDTH; i++)
      if (cmt_valid[i] && !(ZERO_EN && cmt_arch[i] == '0))
        rrat_nxt[cmt_arch[i]] = cmt_phys[i];
  end

  // Entries k..tail-1 (circular) die on mispredict; span 0 with k live means the ring was full.
  always_comb begin
    span = tail - br_mispredict_id;
    off  = '0;
    for (int e = 0; e < NUM_CKPT; e++) begin
      off         = CK_BITS'(e) - br_mispredict_id;
      clr_mask[e] = (span == '0) || (off < span);
    end
  end

  // Checkpoint valid bits: flush > mispredict > resolve/allocate.
  always_comb begin
    vld_nxt = ckpt_vld;
    if (flush) vld_nxt = '0;
    else if (br_mispredict) vld_nxt = ckpt_vld & ~clr_mask;
    else begin
      if (br_resolve_valid) vld_nxt[br_resolve_id] = 1'b0;
      if (alloc) vld_nxt[tail] = 1'b1;
    end
  end

  // RAT state, tail and valid bits; commits always land in the retirement RAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_ARCH; r++) begin
        spec_rat[r] <= PHYS_BITS'(r);
        rrat[r]     <= PHYS_BITS'(r);
      end
      ckpt_vld <= '0;
      tail     <= '0;
    end else begin
      rrat     <= rrat_nxt;
      ckpt_vld <= vld_nxt;
      if (flush) begin
        spec_rat <= rrat_nxt;
        tail     <= '0;
      end else if (br_mispredict) begin
        spec_rat <= ckpt[br_mispredict_id];
        tail     <= br_mispredict_id;
      end else begin
        if (ren_fire) spec_rat <= grp_upd[WIDTH-1];
        if (alloc)    tail     <= tail + 1'b1;
      end
    end
  end

  // Checkpoint storage: snapshot of slots 0..ckpt_slot at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CKPT; c++)
        for (int r = 0; r < NUM_ARCH; r++)
          ckpt[c][r] <= PHYS_BITS'(r);
    end else if (alloc) begin
      ckpt[tail] <= grp_upd[ckpt_slot];
    end
  end

`ifndef SYNTHESIS
  // A mispredict must name a live checkpoint.
  always @(posedge clk)
    if (rst_n && br_mispredict && !flush)
      assert (ckpt_vld[br_mispredict_id])
        else $error("mispredict of free checkpoint %0d", br_mispredict_id);
`endif
endmodule

// File: tb/tb_superh16_rat_ckpt.sv
// Bench for superh16_rat_ckpt: directed scenarios plus randomized traffic
// against a sequential array model of the rename table and checkpoint ring.
module tb_superh16_rat_ckpt;
  localparam int NA = 32, PB = 8, W = 12, S = 3, NC = 8, AB = 5, CB = 3, SB = 4;
`ifdef SUPERH16_RAT_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic ren_fire, ckpt_req, ckpt_full, br_resolve_valid, br_mispredict, flush;
  logic [W*S-1:0][AB-1:0] ren_src_arch;
  logic [W*S-1:0][PB-1:0] ren_src_phys;
  logic [W-1:0] ren_dst_valid, cmt_valid;
  logic [W-1:0][AB-1:0] ren_dst_arch, cmt_arch;
  logic [W-1:0][PB-1:0] ren_dst_phys, ren_old_phys, cmt_phys;
  logic [SB-1:0] ckpt_slot;
  logic [CB-1:0] ckpt_id, br_resolve_id, br_mispredict_id;

  always #5 clk = ~clk;

  superh16_rat_ckpt dut (
    .clk(clk), .rst_n(rst_n), .ren_fire(ren_fire),
    .ren_src_arch(ren_src_arch), .ren_src_phys(ren_src_phys),
    .ren_dst_valid(ren_dst_valid), .ren_dst_arch(ren_dst_arch),
    .ren_dst_phys(ren_dst_phys), .ren_old_phys(ren_old_phys),
    .ckpt_req(ckpt_req), .ckpt_slot(ckpt_slot), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .br_resolve_valid(br_resolve_valid), .br_resolve_id(br_resolve_id),
    .br_mispredict(br_mispredict), .br_mispredict_id(br_mispredict_id),
    .cmt_valid(cmt_valid), .cmt_arch(cmt_arch), .cmt_phys(cmt_phys), .flush(flush)
  );

  int checks = 0, failures = 0;

  // Reference model: plain arrays updated one slot at a time.
  logic [PB-1:0] m_rat [NA];
  logic [PB-1:0] m_rrat [NA];
  logic [PB-1:0] m_ck [NC][NA];
  bit            m_vld [NC];
  int            m_tail;
  logic [PB-1:0] e_src [W*S];
  logic [PB-1:0] e_old [W];

  function automatic logic [PB-1:0] rd(input logic [PB-1:0] t [NA], input int a);
    return (ZR && a == 0) ? '0 : t[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NA; r++) begin
      m_rat[r] = PB'(r); m_rrat[r] = PB'(r);
      for (int c = 0; c < NC; c++) m_ck[c][r] = PB'(r);
    end
    for (int c = 0; c < NC; c++) m_vld[c] = 0;
    m_tail = 0;
  endtask

  // Expected lookups: each slot sees the table as left by all older slots.
  task automatic model_lookup();
    logic [PB-1:0] work [NA];
    work = m_rat;
    for (int i = 0; i < W; i++) begin
      for (int s = 0; s < S; s++) e_src[i*S+s] = rd(work, int'(ren_src_arch[i*S+s]));
      e_old[i] = rd(work, int'(ren_dst_arch[i]));
      if (ren_dst_valid[i] && !(ZR && ren_dst_arch[i] == 0)) work[ren_dst_arch[i]] = ren_dst_phys[i];
    end
  endtask

  task automatic model_clock();
    logic [PB-1:0] work [NA], snap [NA], rn [NA];
    bit alloc;
    int t;
    work = m_rat; snap = m_rat; rn = m_rrat;
    for (int i = 0; i < W; i++) begin
      if (ren_dst_valid[i] && !(ZR && ren_dst_arch[i] == 0)) work[ren_dst_arch[i]] = ren_dst_phys[i];
      if (i == int'(ckpt_slot)) snap = work;
      if (cmt_valid[i] && !(ZR && cmt_arch[i] == 0)) rn[cmt_arch[i]] = cmt_phys[i];
    end
    alloc = ren_fire && ckpt_req && !m_vld[m_tail];
    if (flush) begin
      m_rat = rn;
      for (int c = 0; c < NC; c++) m_vld[c] = 0;
      m_tail = 0;
    end else if (br_mispredict) begin
      m_rat = m_ck[br_mispredict_id];
      t = int'(br_mispredict_id);
      do begin m_vld[t] = 0; t = (t + 1) % NC; end while (t != m_tail);
      m_tail = int'(br_mispredict_id);
    end else begin
      if (br_resolve_valid) m_vld[br_resolve_id] = 0;
      if (ren_fire) m_rat = work;
      if (alloc) begin
        m_ck[m_tail] = snap; m_vld[m_tail] = 1; m_tail = (m_tail + 1) % NC;
      end
    end
    m_rrat = rn;
  endtask

  task automatic idle();
    ren_fire = 0; ren_src_arch = '0; ren_dst_valid = '0; ren_dst_arch = '0; ren_dst_phys = '0;
    ckpt_req = 0; ckpt_slot = '0; br_resolve_valid = 0; br_resolve_id = '0;
    br_mispredict = 0; br_mispredict_id = '0; cmt_valid = '0; cmt_arch = '0; cmt_phys = '0;
    flush = 0;
  endtask

  // Source r of the group reads arch r, so sources 0..NA-1 dump the RAT.
  task automatic read_all();
    idle();
    for (int r = 0; r < NA; r++) ren_src_arch[r] = AB'(r);
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic rand_stim();
    int id;
    idle();
    ren_fire = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < W; i++) begin
      ren_dst_valid[i] = $urandom_range(0, 1);
      ren_dst_arch[i]  = AB'($urandom_range(0, NA-1));
      ren_dst_phys[i]  = PB'($urandom);
      for (int s = 0; s < S; s++) ren_src_arch[i*S+s] = AB'($urandom_range(0, NA-1));
      cmt_valid[i] = ($urandom_range(0, 2) == 0);
      cmt_arch[i]  = AB'($urandom_range(0, NA-1));
      cmt_phys[i]  = PB'($urandom);
    end
    ckpt_req  = ($urandom_range(0, 2) == 0);
    ckpt_slot = SB'($urandom_range(0, W-1));
    id = $urandom_range(0, NC-1);
    if (m_vld[id] && $urandom_range(0, 3) == 0) begin br_resolve_valid = 1; br_resolve_id = CB'(id); end
    id = $urandom_range(0, NC-1);
    if (m_vld[id] && $urandom_range(0, 11) == 0) begin br_mispredict = 1; br_mispredict_id = CB'(id); end
    flush = ($urandom_range(0, 39) == 0);
  endtask

  task automatic test_reset();
    logic [PB-1:0] ex;
    do_reset();
    read_all(); #1;
    for (int r = 0; r < NA; r++) begin
      ex = (ZR && r == 0) ? '0 : PB'(r);
      checks++; if (ren_src_phys[r] !== ex) begin failures++; $display("FAIL reset_rat[%0d] got=%0d exp=%0d", r, ren_src_phys[r], ex); end
    end
    checks++; if (ckpt_id !== 3'd0) begin failures++; $display("FAIL reset_ckpt_id got=%0d exp=0", ckpt_id); end
    checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL reset_ckpt_full got=%0b exp=0", ckpt_full); end
  endtask

  task automatic test_bypass();
    do_reset(); idle();
    ren_fire = 1;
    ren_dst_valid[0] = 1; ren_dst_arch[0] = 5; ren_dst_phys[0] = 40;
    ren_dst_valid[1] = 1; ren_dst_arch[1] = 7; ren_dst_phys[1] = 41;
    ren_dst_valid[2] = 1; ren_dst_arch[2] = 7; ren_dst_phys[2] = 42;
    ren_src_arch[3*S] = 5;
    ren_src_arch[0] = 5;
    #1;
    checks++; if (ren_src_phys[3*S] !== 8'd40) begin failures++; $display("FAIL bypass_slot3_src got=%0d exp=40", ren_src_phys[3*S]); end
    checks++; if (ren_src_phys[0] !== 8'd5) begin failures++; $display("FAIL bypass_slot0_src_no_self got=%0d exp=5", ren_src_phys[0]); end
    checks++; if (ren_old_phys[0] !== 8'd5) begin failures++; $display("FAIL bypass_slot0_old got=%0d exp=5", ren_old_phys[0]); end
    checks++; if (ren_old_phys[1] !== 8'd7) begin failures++; $display("FAIL bypass_slot1_old got=%0d exp=7", ren_old_phys[1]); end
    checks++; if (ren_old_phys[2] !== 8'd41) begin failures++; $display("FAIL bypass_slot2_old got=%0d exp=41", ren_old_phys[2]); end
    tick();
    read_all(); #1;
    checks++; if (ren_src_phys[7] !== 8'd42) begin failures++; $display("FAIL waw_rat_r7 got=%0d exp=42", ren_src_phys[7]); end
    checks++; if (ren_src_phys[5] !== 8'd40) begin failures++; $display("FAIL waw_rat_r5 got=%0d exp=40", ren_src_phys[5]); end
  endtask

  task automatic test_partial_ckpt();
    do_reset(); idle();
    ren_fire = 1; ckpt_req = 1; ckpt_slot = 2;
    ren_dst_valid[0] = 1; ren_dst_arch[0] = 1; ren_dst_phys[0] = 50;
    ren_dst_valid[4] = 1; ren_dst_arch[4] = 2; ren_dst_phys[4] = 51;
    #1;
    checks++; if (ckpt_id !== 3'd0) begin failures++; $display("FAIL pckpt_grant got=%0d exp=0", ckpt_id); end
    tick();
    read_all(); #1;
    checks++; if (ren_src_phys[2] !== 8'd51) begin failures++; $display("FAIL pckpt_rat_r2 got=%0d exp=51", ren_src_phys[2]); end
    checks++; if (ckpt_id !== 3'd1) begin failures++; $display("FAIL pckpt_tail got=%0d exp=1", ckpt_id); end
    idle(); br_mispredict = 1; br_mispredict_id = 0; ren_fire = 1; ckpt_req = 1;
    ren_dst_valid[0] = 1; ren_dst_arch[0] = 1; ren_dst_phys[0] = 99;
    tick();
    read_all(); #1;
    checks++; if (ren_src_phys[1] !== 8'd50) begin failures++; $display("FAIL misp_rat_r1 got=%0d exp=50", ren_src_phys[1]); end
    checks++; if (ren_src_phys[2] !== 8'd2) begin failures++; $display("FAIL misp_rat_r2 got=%0d exp=2", ren_src_phys[2]); end
    checks++; if (ckpt_id !== 3'd0) begin failures++; $display("FAIL misp_tail got=%0d exp=0", ckpt_id); end
    checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL misp_full got=%0b exp=0", ckpt_full); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < NC; i++) begin
      idle(); ren_fire = 1; ckpt_req = 1; #1;
      checks++; if (ckpt_id !== CB'(i) || ckpt_full !== 1'b0) begin failures++; $display("FAIL fill_grant[%0d] got=%0d/%0b exp=%0d/0", i, ckpt_id, ckpt_full, i); end
      tick();
    end
    checks++; if (ckpt_full !== 1'b1 || ckpt_id !== 3'd0) begin failures++; $display("FAIL full_set got=%0b/%0d exp=1/0", ckpt_full, ckpt_id); end
    idle(); ren_fire = 1; ckpt_req = 1; tick();
    checks++; if (ckpt_full !== 1'b1 || ckpt_id !== 3'd0) begin failures++; $display("FAIL full_req_ignored got=%0b/%0d exp=1/0", ckpt_full, ckpt_id); end
    idle(); br_resolve_valid = 1; br_resolve_id = 3; tick();
    checks++; if (ckpt_full !== 1'b1) begin failures++; $display("FAIL resolve3_full got=%0b exp=1", ckpt_full); end
    idle(); br_resolve_valid = 1; br_resolve_id = 0; tick();
    checks++; if (ckpt_full !== 1'b0 || ckpt_id !== 3'd0) begin failures++; $display("FAIL resolve0 got=%0b/%0d exp=0/0", ckpt_full, ckpt_id); end
    idle(); ren_fire = 1; ckpt_req = 1; br_resolve_valid = 1; br_resolve_id = 5; tick();
    checks++; if (ckpt_id !== 3'd1 || ckpt_full !== 1'b1) begin failures++; $display("FAIL realloc got=%0d/%0b exp=1/1", ckpt_id, ckpt_full); end
  endtask

  task automatic test_nested_mispredict();
    do_reset();
    for (int i = 0; i < 3; i++) begin idle(); ren_fire = 1; ckpt_req = 1; tick(); end
    idle(); br_mispredict = 1; br_mispredict_id = 1; tick();
    checks++; if (ckpt_id !== 3'd1 || ckpt_full !== 1'b0) begin failures++; $display("FAIL nest_tail got=%0d/%0b exp=1/0", ckpt_id, ckpt_full); end
    idle(); ren_fire = 1; ckpt_req = 1; tick();
    checks++; if (ckpt_id !== 3'd2 || ckpt_full !== 1'b0) begin failures++; $display("FAIL nest_id2_freed got=%0d/%0b exp=2/0", ckpt_id, ckpt_full); end
    for (int i = 0; i < 6; i++) begin idle(); ren_fire = 1; ckpt_req = 1; tick(); end
    checks++; if (ckpt_id !== 3'd0 || ckpt_full !== 1'b1) begin failures++; $display("FAIL nest_id0_kept got=%0d/%0b exp=0/1", ckpt_id, ckpt_full); end
  endtask

  task automatic test_flush_commit();
    do_reset(); idle();
    ren_fire = 1; ckpt_req = 1; ren_dst_valid[0] = 1; ren_dst_arch[0] = 3; ren_dst_phys[0] = 90;
    cmt_valid[0] = 1; cmt_arch[0] = 3; cmt_phys[0] = 60;
    tick();
    idle();
    ren_fire = 1; ckpt_req = 1; ren_dst_valid[0] = 1; ren_dst_arch[0] = 4; ren_dst_phys[0] = 91;
    cmt_valid[0] = 1; cmt_arch[0] = 4; cmt_phys[0] = 61; flush = 1;
    tick();
    read_all(); #1;
    checks++; if (ren_src_phys[3] !== 8'd60) begin failures++; $display("FAIL flush_r3 got=%0d exp=60", ren_src_phys[3]); end
    checks++; if (ren_src_phys[4] !== 8'd61) begin failures++; $display("FAIL flush_r4 got=%0d exp=61", ren_src_phys[4]); end
    checks++; if (ren_src_phys[5] !== 8'd5) begin failures++; $display("FAIL flush_r5 got=%0d exp=5", ren_src_phys[5]); end
    checks++; if (ckpt_id !== 3'd0 || ckpt_full !== 1'b0) begin failures++; $display("FAIL flush_ckpt got=%0d/%0b exp=0/0", ckpt_id, ckpt_full); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rand_stim(); #1;
      model_lookup();
      for (int k = 0; k < W*S; k++) begin
        checks++; if (ren_src_phys[k] !== e_src[k]) begin failures++; $display("FAIL rnd_src c=%0d k=%0d got=%0d exp=%0d", c, k, ren_src_phys[k], e_src[k]); end
      end
      for (int i = 0; i < W; i++) begin
        checks++; if (ren_old_phys[i] !== e_old[i]) begin failures++; $display("FAIL rnd_old c=%0d i=%0d got=%0d exp=%0d", c, i, ren_old_phys[i], e_old[i]); end
      end
      checks++; if (ckpt_id !== CB'(m_tail) || ckpt_full !== m_vld[m_tail]) begin failures++; $display("FAIL rnd_ckpt c=%0d got=%0d/%0b exp=%0d/%0b", c, ckpt_id, ckpt_full, m_tail, m_vld[m_tail]); end
      tick();
    end
    read_all(); #1;
    for (int r = 0; r < NA; r++) begin
      checks++; if (ren_src_phys[r] !== rd(m_rat, r)) begin failures++; $display("FAIL rnd_final_rat[%0d] got=%0d exp=%0d", r, ren_src_phys[r], rd(m_rat, r)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [PB-1:0] ex;
    for (int c = 0; c < 20; c++) begin rand_stim(); br_mispredict = 0; flush = 0; ren_fire = 1; ckpt_req = 1; tick(); end
    read_all();
    #2 rst_n = 0;
    #1;
    for (int r = 0; r < NA; r++) begin
      ex = (ZR && r == 0) ? '0 : PB'(r);
      checks++; if (ren_src_phys[r] !== ex) begin failures++; $display("FAIL midrst_rat[%0d] got=%0d exp=%0d", r, ren_src_phys[r], ex); end
    end
    checks++; if (ckpt_id !== 3'd0 || ckpt_full !== 1'b0) begin failures++; $display("FAIL midrst_ckpt got=%0d/%0b exp=0/0", ckpt_id, ckpt_full); end
    @(posedge clk); #1 rst_n = 1;
    model_reset();
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_partial_ckpt();
    test_full_wrap();
    test_nested_mispredict();
    test_flush_commit();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
